// File: rtl/alu_sequencer.sv
// Request/response wrapper around a combinational ALU. It registers operands onto the ALU,
// waits extra cycles for mul/div/rem, captures the result and holds the response until consumed.
module alu_sequencer #(
    parameter int unsigned MULDIV_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_shamt,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [3:0]  alu_op,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_negative,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_negative,
    output logic        rsp_err,
    output logic        busy
);
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;

    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1101;
    localparam logic [3:0] OP_REM = 4'b1110;
    localparam logic [3:0] OP_ILL = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] alu_data1_q, alu_data1_d;
    logic [DW-1:0] alu_data2_q, alu_data2_d;
    logic [3:0]    alu_op_q, alu_op_d;
    logic [4:0]    alu_shamt_q, alu_shamt_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_zero_q, rsp_zero_d;
    logic          rsp_negative_q, rsp_negative_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          req_ready_q, req_ready_d;
    logic          busy_q, busy_d;

    logic is_divrem_c;
    logic is_muldiv_c;
    logic is_err_c;

    always_comb begin
        is_divrem_c = (req_op == OP_DIV) || (req_op == OP_REM);
        is_muldiv_c = is_divrem_c || (req_op == OP_MUL);
        is_err_c    = (req_op == OP_ILL) || (is_divrem_c && (req_b == '0));
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        alu_data1_d    = alu_data1_q;
        alu_data2_d    = alu_data2_q;
        alu_op_d       = alu_op_q;
        alu_shamt_d    = alu_shamt_q;
        rsp_data_d     = rsp_data_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_negative_d = rsp_negative_q;
        rsp_err_d      = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    alu_data1_d = req_a;
                    alu_data2_d = req_b;
                    alu_op_d    = req_op;
                    alu_shamt_d = req_shamt;
                    if (is_err_c) begin
                        state_d        = S_DONE;
                        rsp_data_d     = '0;
                        rsp_zero_d     = 1'b0;
                        rsp_negative_d = 1'b0;
                        rsp_err_d      = 1'b1;
                    end else if (is_muldiv_c && (MULDIV_WAIT != 0)) begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(MULDIV_WAIT);
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rsp_data_d     = alu_out;
                rsp_zero_d     = alu_zero;
                rsp_negative_d = alu_negative;
                rsp_err_d      = 1'b0;
                state_d        = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            alu_data1_q    <= '0;
            alu_data2_q    <= '0;
            alu_op_q       <= 4'b0000;
            alu_shamt_q    <= '0;
            rsp_data_q     <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_negative_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_valid_q    <= 1'b0;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            alu_data1_q    <= alu_data1_d;
            alu_data2_q    <= alu_data2_d;
            alu_op_q       <= alu_op_d;
            alu_shamt_q    <= alu_shamt_d;
            rsp_data_q     <= rsp_data_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_negative_q <= rsp_negative_d;
            rsp_err_q      <= rsp_err_d;
            rsp_valid_q    <= rsp_valid_d;
            req_ready_q    <= req_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign alu_data1    = alu_data1_q;
    assign alu_data2    = alu_data2_q;
    assign alu_op       = alu_op_q;
    assign alu_shamt    = alu_shamt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_negative = rsp_negative_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU closing the loop.
`timescale 1ns/1ps
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_shamt;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_negative;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_negative;
    logic        rsp_err;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    alu_sequencer #(.MULDIV_WAIT(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_negative(rsp_negative), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference ALU: add, sub, mul, div, rem; anything else yields zero
    always_comb begin
        case (alu_op)
            4'b0001: alu_out = alu_data1 + alu_data2;
            4'b0010: alu_out = alu_data1 - alu_data2;
            4'b1100: alu_out = alu_data1 * alu_data2;
            4'b1101: alu_out = (alu_data2 != 0) ? alu_data1 / alu_data2 : 32'd0;
            4'b1110: alu_out = (alu_data2 != 0) ? alu_data1 % alu_data2 : 32'd0;
            default: alu_out = 32'd0;
        endcase
        alu_zero     = (alu_out == 32'd0);
        alu_negative = alu_out[31];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE, follow it until the sequencer is idle again (rsp_ready held)
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcyc, output logic [31:0] d,
                       output logic z, output logic n, output logic e);
        lat = 0; bcyc = 0; d = 'x; z = 1'bx; n = 1'bx; e = 1'bx;
        req_op = op; req_a = a; req_b = b; req_shamt = 5'd17; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k < 40; k++) begin
            if (rsp_valid && lat == 0) begin
                lat = k; d = rsp_data; z = rsp_zero; n = rsp_negative; e = rsp_err;
            end
            if (!busy) break;
            bcyc++;
            @(posedge clk); #1;
        end
    endtask

    int          lat, bcyc;
    logic [31:0] d;
    logic        z, n, e;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        req_shamt = '0; rsp_ready = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_data1", alu_data1, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        // Add
        run(4'b0001, 32'd5, 32'd7, lat, bcyc, d, z, n, e);
        chk("add_lat", 32'(lat), 32'd2);
        chk("add_busy", 32'(bcyc), 32'd2);
        chk("add_data", d, 32'd12);
        chk("add_flags", {29'd0, z, n, e}, 32'd0);
        chk("add_alu_op", 32'(alu_op), 32'b0001);
        chk("add_alu_d1", alu_data1, 32'd5);
        chk("add_alu_d2", alu_data2, 32'd7);
        chk("add_alu_shamt", 32'(alu_shamt), 32'd17);

        // Subtract to negative, then to zero
        run(4'b0010, 32'd3, 32'd10, lat, bcyc, d, z, n, e);
        chk("sub_neg_data", d, 32'hFFFF_FFF9);
        chk("sub_neg_flags", {29'd0, z, n, e}, 32'b010);
        run(4'b0010, 32'd9, 32'd9, lat, bcyc, d, z, n, e);
        chk("sub_zero_data", d, 32'd0);
        chk("sub_zero_flags", {29'd0, z, n, e}, 32'b100);

        // Divide and remainder with three extra wait cycles
        run(4'b1101, 32'd100, 32'd7, lat, bcyc, d, z, n, e);
        chk("div_lat", 32'(lat), 32'd5);
        chk("div_busy", 32'(bcyc), 32'd5);
        chk("div_data", d, 32'd14);
        run(4'b1110, 32'd100, 32'd7, lat, bcyc, d, z, n, e);
        chk("rem_lat", 32'(lat), 32'd5);
        chk("rem_data", d, 32'd2);

        // Errors: divide by zero, illegal op
        run(4'b1101, 32'd55, 32'd0, lat, bcyc, d, z, n, e);
        chk("divz_lat", 32'(lat), 32'd1);
        chk("divz_busy", 32'(bcyc), 32'd1);
        chk("divz_err", 32'(e), 32'd1);
        chk("divz_data", d, 32'd0);
        chk("divz_alu_d1", alu_data1, 32'd55);
        chk("err_retained", 32'(rsp_err), 32'd1);
        run(4'b1110, 32'd8, 32'd0, lat, bcyc, d, z, n, e);
        chk("remz_err", 32'(e), 32'd1);
        run(4'b1111, 32'd1, 32'd2, lat, bcyc, d, z, n, e);
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_err", 32'(e), 32'd1);
        chk("ill_flags", {29'd0, z, n, 1'b0}, 32'd0);

        // Backpressure: response held for 10 cycles, new requests ignored
        rsp_ready = 1'b0;
        req_op = 4'b0001; req_a = 32'd20; req_b = 32'd22; req_shamt = 5'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_first_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            req_op = 4'b0010; req_a = 32'd1; req_b = 32'd1; req_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, 32'd42);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        chk("bp_alu_op_kept", 32'(alu_op), 32'b0001);
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        chk("bp_no_accept_on_consume", 32'(alu_op), 32'b0001);
        chk("bp_data_retained", rsp_data, 32'd42);
        req_valid = 1'b0;

        // Reset in the middle of a multiply wait
        run(4'b0001, 32'd1, 32'd1, lat, bcyc, d, z, n, e);
        req_op = 4'b1100; req_a = 32'd6; req_b = 32'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mul_in_wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_alu_d1", alu_data1, 32'd0);
        chk("midrst_alu_op", 32'(alu_op), 32'd0);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        @(negedge clk); rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) lat++;
        end
        chk("midrst_no_rsp", 32'(lat), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        run(4'b1100, 32'd6, 32'd7, lat, bcyc, d, z, n, e);
        chk("mul_lat", 32'(lat), 32'd5);
        chk("mul_data", d, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
